// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: FSM states, PC and forwarding selects,
// result-source codes and the load-use detection helper.
package hazard_pkg;

    localparam int TRAP_CNT_W = 4;   // holds TRAP_FLUSH_CYCLES-1 (0..14)
    localparam int WAIT_CNT_W = 8;   // holds MEM_WAIT_MAX (1..255)

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_e;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_MTVEC  = 2'b10;
    localparam logic [1:0] PC_SEL_MEPC   = 2'b11;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    // A load in E whose destination is read by the instruction in D.
    function automatic logic load_use_hit(
        input logic [1:0] result_src_e,
        input logic [4:0] rd_e,
        input logic [4:0] rs1_d,
        input logic [4:0] rs2_d
    );
        return (result_src_e == RES_SRC_LOAD) && (rd_e != 5'd0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
    endfunction

endpackage

// File: rtl/hazard_ctl_fwd.sv
// Combinational EX-stage forwarding select for one source operand; M beats W,
// and x0 is never forwarded.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       wr_m,
    input  logic       wr_w,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: stage enables/flushes, PC select, forwarding and trap sequencing.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush/wait performance counters.
module hazard_ctl
    import hazard_pkg::*;
#(
    parameter int unsigned TRAP_FLUSH_CYCLES = 2,
    parameter int unsigned MEM_WAIT_MAX      = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_rs1_d,
    input  logic [4:0]  i_rs2_d,
    input  logic [4:0]  i_rs1_e,
    input  logic [4:0]  i_rs2_e,
    input  logic [4:0]  i_rd_e,
    input  logic [4:0]  i_rd_m,
    input  logic [4:0]  i_rd_w,
    input  logic        i_reg_wr_m,
    input  logic        i_reg_wr_w,
    input  logic [1:0]  i_result_src_e,
    input  logic        i_pc_src_e,
    input  logic        i_ecall_m,
    input  logic        i_mret_m,
    input  logic        i_mem_busy,
    output logic        o_if_id_clk_en,
    output logic        o_id_ex_clk_en,
    output logic        o_ex_mem_clk_en,
    output logic        o_pc_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_id_ex_flush_exception_m,
    output logic [1:0]  o_pc_sel,
    output logic [1:0]  o_fwd_a_e,
    output logic [1:0]  o_fwd_b_e,
    output logic [1:0]  o_state,
    output logic        o_mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt,
    output logic [31:0] o_wait_cnt
`endif
);

    localparam logic [TRAP_CNT_W-1:0] TRAP_LOAD = TRAP_CNT_W'(TRAP_FLUSH_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = WAIT_CNT_W'(MEM_WAIT_MAX);

    state_e                state_q, state_d;
    logic [TRAP_CNT_W-1:0] trap_q, trap_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic                  stall_q, stall;
    logic                  timeout_q;
    logic                  run_rules;
    logic                  load_use;

    // ------------------------------------------------------------------
    // Forwarding: one compare unit per EX operand.
    // ------------------------------------------------------------------
    logic [1:0][4:0] rs_e;
    logic [1:0][1:0] fwd_sel;

    assign rs_e[0] = i_rs1_e;
    assign rs_e[1] = i_rs2_e;

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        hazard_fwd_unit u_fwd (
            .rs   (rs_e[g]),
            .rd_m (i_rd_m),
            .rd_w (i_rd_w),
            .wr_m (i_reg_wr_m),
            .wr_w (i_reg_wr_w),
            .sel  (fwd_sel[g])
        );
    end

    assign o_fwd_a_e = fwd_sel[0];
    assign o_fwd_b_e = fwd_sel[1];

    assign load_use = load_use_hit(i_result_src_e, i_rd_e, i_rs1_d, i_rs2_d);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // through the case/if tree leaves a value unassigned (which would infer a latch).
        state_d                   = ST_RUN;
        trap_d                    = trap_q;
        wait_d                    = '0;
        stall                     = 1'b0;
        run_rules                 = 1'b0;
        o_if_id_clk_en            = 1'b1;
        o_id_ex_clk_en            = 1'b1;
        o_ex_mem_clk_en           = 1'b1;
        o_pc_en                   = 1'b1;
        o_if_id_flush             = 1'b0;
        o_id_ex_flush             = 1'b0;
        o_id_ex_flush_exception_m = 1'b0;
        o_pc_sel                  = PC_SEL_PLUS4;

        case (state_q)
            ST_MEM_WAIT: begin
                if (i_mem_busy) begin
                    state_d         = ST_MEM_WAIT;
                    wait_d          = (wait_q >= WAIT_MAX) ? WAIT_MAX : wait_q + 1'b1;
                    o_if_id_clk_en  = 1'b0;
                    o_id_ex_clk_en  = 1'b0;
                    o_ex_mem_clk_en = 1'b0;
                    o_pc_en         = 1'b0;
                end else begin
                    // Memory released: this cycle already behaves as RUN.
                    run_rules = 1'b1;
                end
            end

            ST_TRAP: begin
                o_id_ex_flush_exception_m = (trap_q != '0);
                o_if_id_flush             = (trap_q != '0);
                if (i_mem_busy) begin
                    state_d         = ST_TRAP;
                    o_if_id_clk_en  = 1'b0;
                    o_id_ex_clk_en  = 1'b0;
                    o_ex_mem_clk_en = 1'b0;
                    o_pc_en         = 1'b0;
                end else if (trap_q > TRAP_CNT_W'(1)) begin
                    state_d = ST_TRAP;
                    trap_d  = trap_q - 1'b1;
                end else begin
                    trap_d = '0;
                end
            end

            // RUN, and the unused encoding which falls back to RUN.
            default: run_rules = 1'b1;
        endcase

        if (run_rules) begin
            if (i_mem_busy) begin
                state_d         = ST_MEM_WAIT;
                wait_d          = WAIT_CNT_W'(1);
                o_if_id_clk_en  = 1'b0;
                o_id_ex_clk_en  = 1'b0;
                o_ex_mem_clk_en = 1'b0;
                o_pc_en         = 1'b0;
            end else if (i_ecall_m || i_mret_m) begin
                state_d                   = ST_TRAP;
                trap_d                    = TRAP_LOAD;
                o_pc_sel                  = i_ecall_m ? PC_SEL_MTVEC : PC_SEL_MEPC;
                o_id_ex_flush_exception_m = 1'b1;
                o_if_id_flush             = 1'b1;
            end else if (i_pc_src_e) begin
                o_pc_sel      = PC_SEL_BRANCH;
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
            end else if (load_use && !stall_q) begin
                // One bubble is enough: the load has reached M on the next cycle.
                stall          = 1'b1;
                o_pc_en        = 1'b0;
                o_if_id_clk_en = 1'b0;
                o_id_ex_flush  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q   <= ST_RUN;
            trap_q    <= '0;
            wait_q    <= '0;
            stall_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            wait_q  <= wait_d;
            stall_q <= stall;
            if (wait_d == WAIT_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_state       = state_q;
    assign o_mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, wait_cyc_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cyc_q  <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (o_if_id_flush || o_id_ex_flush || o_id_ex_flush_exception_m) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if (state_q == ST_MEM_WAIT) begin
                wait_cyc_q <= wait_cyc_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
    assign o_wait_cnt  = wait_cyc_q;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Self-checking bench for hazard_ctl: directed scenarios plus randomized traffic,
// all compared against a cycle-level behavioural model of the controller's rules.
module tb_hazard_ctl;

    localparam int TF   = 2;
    localparam int WMAX = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_wr_m, reg_wr_w;
    logic [1:0] result_src_e;
    logic       pc_src_e, ecall_m, mret_m, mem_busy;

    logic       if_id_en, id_ex_en, ex_mem_en, pc_en;
    logic       if_id_flush, id_ex_flush, exc_flush;
    logic [1:0] pc_sel, fwd_a, fwd_b, state;
    logic       timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int burst  = 0;

    // Behavioural model: trap residency, consecutive busy cycles, sticky timeout.
    bit         m_in_trap, n_in_trap;
    int         m_left, n_left;
    int         m_busy_run, n_busy_run;
    bit         m_timeout, n_timeout;
    bit         m_stalled, n_stalled;
    logic [15:0] exp_vec;

    always #5 clk = ~clk;

    hazard_ctl #(
        .TRAP_FLUSH_CYCLES (TF),
        .MEM_WAIT_MAX      (WMAX)
    ) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_rs1_d                   (rs1_d),
        .i_rs2_d                   (rs2_d),
        .i_rs1_e                   (rs1_e),
        .i_rs2_e                   (rs2_e),
        .i_rd_e                    (rd_e),
        .i_rd_m                    (rd_m),
        .i_rd_w                    (rd_w),
        .i_reg_wr_m                (reg_wr_m),
        .i_reg_wr_w                (reg_wr_w),
        .i_result_src_e            (result_src_e),
        .i_pc_src_e                (pc_src_e),
        .i_ecall_m                 (ecall_m),
        .i_mret_m                  (mret_m),
        .i_mem_busy                (mem_busy),
        .o_if_id_clk_en            (if_id_en),
        .o_id_ex_clk_en            (id_ex_en),
        .o_ex_mem_clk_en           (ex_mem_en),
        .o_pc_en                   (pc_en),
        .o_if_id_flush             (if_id_flush),
        .o_id_ex_flush             (id_ex_flush),
        .o_id_ex_flush_exception_m (exc_flush),
        .o_pc_sel                  (pc_sel),
        .o_fwd_a_e                 (fwd_a),
        .o_fwd_b_e                 (fwd_b),
        .o_state                   (state),
        .o_mem_timeout             (timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cnt               (stall_cnt),
        .o_flush_cnt               (flush_cnt),
        .o_wait_cnt                (wait_cnt)
`endif
    );

    function automatic logic [15:0] obs_vec();
        return {if_id_en, id_ex_en, ex_mem_en, pc_en, if_id_flush, id_ex_flush, exc_flush,
                pc_sel, fwd_a, fwd_b, state, timeout};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (reg_wr_m && rd_m != 5'd0 && rd_m == rs) return 2'b10;
        if (reg_wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function void model_reset();
        m_in_trap  = 1'b0;
        m_left     = 0;
        m_busy_run = 0;
        m_timeout  = 1'b0;
        m_stalled  = 1'b0;
    endfunction

    function void model_eval();
        logic [3:0] en;
        logic       fi, fe, fx, lu;
        logic [1:0] ps, st;
        en = 4'b1111; fi = 1'b0; fe = 1'b0; fx = 1'b0; ps = 2'b00;
        lu = (result_src_e == 2'b01) && (rd_e != 5'd0) && (rd_e == rs1_d || rd_e == rs2_d);
        st = m_in_trap ? 2'd2 : ((m_busy_run > 0) ? 2'd1 : 2'd0);
        n_in_trap  = m_in_trap;
        n_left     = m_left;
        n_busy_run = m_busy_run;
        n_timeout  = m_timeout;
        n_stalled  = 1'b0;
        if (m_in_trap) begin
            fx = (m_left > 0);
            fi = fx;
            if (mem_busy) begin
                en = 4'b0000;
            end else begin
                if (m_left > 0) n_left = m_left - 1;
                if (n_left == 0) n_in_trap = 1'b0;
            end
        end else if (mem_busy) begin
            en         = 4'b0000;
            n_busy_run = m_busy_run + 1;
            if (n_busy_run >= WMAX) n_timeout = 1'b1;
        end else begin
            n_busy_run = 0;
            if (ecall_m || mret_m) begin
                ps = ecall_m ? 2'b10 : 2'b11;
                fx = 1'b1; fi = 1'b1;
                n_in_trap = 1'b1;
                n_left    = TF - 1;
            end else if (pc_src_e) begin
                ps = 2'b01; fi = 1'b1; fe = 1'b1;
            end else if (lu && !m_stalled) begin
                en = 4'b0110; fe = 1'b1; n_stalled = 1'b1;
            end
        end
        exp_vec = {en, fi, fe, fx, ps, ref_fwd(rs1_e), ref_fwd(rs2_e), st, m_timeout};
    endfunction

    function void model_commit();
        m_in_trap  = n_in_trap;
        m_left     = n_left;
        m_busy_run = n_busy_run;
        m_timeout  = n_timeout;
        m_stalled  = n_stalled;
    endfunction

    task set_idle();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        reg_wr_m = 1'b0; reg_wr_w = 1'b0; result_src_e = 2'b00;
        pc_src_e = 1'b0; ecall_m = 1'b0; mret_m = 1'b0; mem_busy = 1'b0;
    endtask

    task tick();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task test_reset();
        rst = 1'b1;
        set_idle();
        #2;
        checks++;
        if (obs_vec() !== 16'hF000) begin
            $display("FAIL reset_outputs got %h want %h", obs_vec(), 16'hF000);
            errors++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        model_eval();
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec) begin
            $display("FAIL after_reset got %h want %h", obs_vec(), exp_vec);
            errors++;
        end
        tick();
    endtask

    task test_load_use();
        set_idle();
        result_src_e = 2'b01; rd_e = 5'd5; rs1_d = 5'd5;
        for (int c = 0; c < 2; c++) begin
            model_eval();
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec) begin
                $display("FAIL load_use_cycle%0d got %h want %h", c, obs_vec(), exp_vec);
                errors++;
            end
            checks++;
            if ({pc_en, if_id_en, id_ex_flush} !== ((c == 0) ? 3'b001 : 3'b110)) begin
                $display("FAIL load_use_bits_cycle%0d got %b", c, {pc_en, if_id_en, id_ex_flush});
                errors++;
            end
            tick();
        end
        rd_e = 5'd0; rs1_d = 5'd0;
        model_eval();
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec || pc_en !== 1'b1) begin
            $display("FAIL load_use_rd0 got %h want %h", obs_vec(), exp_vec);
            errors++;
        end
        tick();
        set_idle();
    endtask

    task test_forwarding();
        set_idle();
        reg_wr_m = 1'b1; rd_m = 5'd3; reg_wr_w = 1'b1; rd_w = 5'd3; rs1_e = 5'd3; rs2_e = 5'd7;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) reg_wr_m = 1'b0;
            if (c == 2) begin rd_m = 5'd0; rd_w = 5'd0; end
            model_eval();
            @(negedge clk);
            checks++;
            if (fwd_a !== ((c == 0) ? 2'b10 : (c == 1) ? 2'b01 : 2'b00) || obs_vec() !== exp_vec) begin
                $display("FAIL fwd_step%0d got %h want %h", c, obs_vec(), exp_vec);
                errors++;
            end
            tick();
        end
        rd_w = 5'd7; reg_wr_w = 1'b1; rd_m = 5'd7; reg_wr_m = 1'b1;
        model_eval();
        @(negedge clk);
        checks++;
        if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin
            $display("FAIL fwd_b_m_priority got a=%b b=%b want a=00 b=10", fwd_a, fwd_b);
            errors++;
        end
        tick();
        set_idle();
    endtask

    task test_trap(input bit use_mret);
        set_idle();
        ecall_m = !use_mret;
        mret_m  = use_mret;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin ecall_m = 1'b0; mret_m = 1'b0; end
            model_eval();
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec) begin
                $display("FAIL trap%0d_cycle%0d got %h want %h", use_mret, c, obs_vec(), exp_vec);
                errors++;
            end
            checks++;
            if ({pc_sel, exc_flush, state} !==
                ((c == 0) ? {(use_mret ? 2'b11 : 2'b10), 1'b1, 2'd0} :
                 (c == 1) ? {2'b00, 1'b1, 2'd2} : {2'b00, 1'b0, 2'd0})) begin
                $display("FAIL trap%0d_seq_cycle%0d got %b", use_mret, c, {pc_sel, exc_flush, state});
                errors++;
            end
            tick();
        end
    endtask

    task test_trap_busy();
        set_idle();
        ecall_m = 1'b1;
        tick();
        ecall_m  = 1'b0;
        mem_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) mem_busy = 1'b0;
            model_eval();
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec) begin
                $display("FAIL trap_busy_cycle%0d got %h want %h", c, obs_vec(), exp_vec);
                errors++;
            end
            if (c == 0) begin
                checks++;
                if ({if_id_en, id_ex_en, ex_mem_en, pc_en, exc_flush, state} !== {4'b0000, 1'b1, 2'd2}) begin
                    $display("FAIL trap_busy_freeze got %b", {if_id_en, id_ex_en, ex_mem_en, pc_en, exc_flush, state});
                    errors++;
                end
            end
            tick();
        end
    endtask

    task test_mem_wait();
        set_idle();
        mem_busy = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            model_eval();
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec || {if_id_en, id_ex_en, ex_mem_en, pc_en} !== 4'b0000 ||
                timeout !== (k > WMAX)) begin
                $display("FAIL mem_wait_cycle%0d got %h want %h", k, obs_vec(), exp_vec);
                errors++;
            end
            tick();
        end
        mem_busy = 1'b0;
        ecall_m  = 1'b1;
        model_eval();
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec || pc_sel !== 2'b10 || state !== 2'd1 || timeout !== 1'b1) begin
            $display("FAIL mem_release_trap got %h want %h", obs_vec(), exp_vec);
            errors++;
        end
        tick();
        ecall_m = 1'b0;
        for (int c = 0; c < 2; c++) begin
            model_eval();
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec) begin
                $display("FAIL mem_after_release%0d got %h want %h", c, obs_vec(), exp_vec);
                errors++;
            end
            tick();
        end
    endtask

    task test_branch_vs_load();
        set_idle();
        pc_src_e = 1'b1; result_src_e = 2'b01; rd_e = 5'd9; rs2_d = 5'd9;
        model_eval();
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec ||
            {pc_sel, if_id_flush, id_ex_flush, pc_en, if_id_en} !== 6'b01_1111) begin
            $display("FAIL branch_vs_load got %h want %h", obs_vec(), exp_vec);
            errors++;
        end
        tick();
        set_idle();
    endtask

    task test_reset_mid_trap();
        set_idle();
        ecall_m = 1'b1;
        tick();
        ecall_m = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({state, exc_flush, if_id_flush} !== 4'b0000) begin
            $display("FAIL reset_mid_trap got %b want 0000", {state, exc_flush, if_id_flush});
            errors++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task test_reset_mid_wait();
        set_idle();
        mem_busy = 1'b1;
        for (int k = 0; k < WMAX + 2; k++) tick();
        checks++;
        if (timeout !== 1'b1 || state !== 2'd1) begin
            $display("FAIL wait_before_reset got to=%b st=%0d want to=1 st=1", timeout, state);
            errors++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({state, timeout} !== 3'b000) begin
            $display("FAIL reset_mid_wait got %b want 000", {state, timeout});
            errors++;
        end
        mem_busy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task test_random();
        set_idle();
        burst = 0;
        for (int c = 0; c < 600; c++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            reg_wr_m = 1'($urandom); reg_wr_w = 1'($urandom);
            result_src_e = 2'($urandom);
            pc_src_e = ($urandom_range(0, 7) == 0);
            ecall_m  = ($urandom_range(0, 15) == 0);
            mret_m   = ($urandom_range(0, 15) == 0);
            if (burst > 0) begin
                mem_busy = 1'b1;
                burst--;
            end else if ($urandom_range(0, 9) == 0) begin
                mem_busy = 1'b1;
                burst = $urandom_range(0, 20);
            end else begin
                mem_busy = 1'b0;
            end
            model_eval();
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec) begin
                $display("FAIL random_cycle%0d got %h want %h", c, obs_vec(), exp_vec);
                errors++;
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_forwarding();
        test_trap(1'b0);
        test_trap(1'b1);
        test_trap_busy();
        test_mem_wait();
        test_branch_vs_load();
        test_reset_mid_trap();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
